// File: rtl/piezo_tone_decoder_if.sv
// rtl/piezo_tone_decoder_if.sv - tone input and decoded-note outputs of piezo_tone_decoder
// The decoder connects through the slave modport; the tone source and consumer use the master modport.
interface piezo_tone_decoder_if #(
  parameter int PW = 12
);
  logic          tone_in;
  logic [2:0]    note_out;
  logic          note_valid;
  logic [PW-1:0] period_out;
  logic          meas_strobe;
  logic          note_change;
  logic [7:0]    change_cnt;

  modport master (
    output tone_in,
    input  note_out,
    input  note_valid,
    input  period_out,
    input  meas_strobe,
    input  note_change,
    input  change_cnt
  );

  modport slave (
    input  tone_in,
    output note_out,
    output note_valid,
    output period_out,
    output meas_strobe,
    output note_change,
    output change_cnt
  );
endinterface

// File: rtl/piezo_tone_decoder.sv
// rtl/piezo_tone_decoder.sv - measures tone_in full periods in time-base ticks and decodes scale notes C..B
// Defining PIEZO_DEC_HIST_EN adds the note_change pulse and change_cnt history counter.
module piezo_tone_decoder #(
  parameter int CLK_DIV = 50,
  parameter int PW      = 12,
  parameter int TOL     = 16,
  parameter int TIMEOUT = 4095,
  parameter int STABLE  = 2
) (
  input  logic                clk,
  input  logic                rst,
  piezo_tone_decoder_if.slave dec
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int SW = $clog2(STABLE + 1);
  localparam logic signed [PW:0] TOL_S = (PW+1)'(TOL);

  typedef enum logic [1:0] {
    SILENT  = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic          tick;
  logic          s1, s2, s3, rise;
  logic [PW-1:0] count;
  logic          at_timeout;
  logic          capture, go_silent;
  logic [PW-1:0] period_out;
  logic          meas_strobe;
  logic [2:0]    code;
  logic signed [PW:0] diff;
  logic [2:0]    last_code, note_out, note_nxt;
  logic          note_valid, valid_nxt;
  logic [SW-1:0] streak, streak_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DW'(1);
  end
  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) {s3, s2, s1} <= 3'b000;
    else     {s3, s2, s1} <= {s2, s1, dec.tone_in};
  end
  assign rise = s2 & ~s3;

  assign at_timeout = (count == PW'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SILENT;
    else     state <= state_nxt;
  end

  // Timeout is checked before rise so a count at TIMEOUT is never captured.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    go_silent = 1'b0;
    case (state)
      SILENT: begin
        if (rise) state_nxt = ARMED;
      end
      ARMED, MEASURE: begin
        if (at_timeout) begin
          state_nxt = SILENT;
          go_silent = 1'b1;
        end else if (rise) begin
          state_nxt = MEASURE;
          capture   = 1'b1;
        end
      end
      default: state_nxt = SILENT;
    endcase
  end

  // A rise in the same cycle as a tick clears the count and the tick is lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                count <= '0;
    else if (state_nxt == SILENT || rise)   count <= '0;
    else if (tick && !at_timeout)           count <= count + PW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_out  <= '0;
      meas_strobe <= 1'b0;
    end else begin
      meas_strobe <= capture;
      if (go_silent)    period_out <= '0;
      else if (capture) period_out <= count;
    end
  end

  function automatic logic [PW-1:0] exp_period(input logic [2:0] k);
    case (k)
      3'd1:    exp_period = PW'(1914);
      3'd2:    exp_period = PW'(1704);
      3'd3:    exp_period = PW'(1518);
      3'd4:    exp_period = PW'(1434);
      3'd5:    exp_period = PW'(1278);
      3'd6:    exp_period = PW'(1138);
      3'd7:    exp_period = PW'(1014);
      default: exp_period = '0;
    endcase
  endfunction

  always_comb begin
    code = 3'd0;
    diff = '0;
    for (int k = 1; k <= 7; k++) begin
      diff = $signed({1'b0, period_out}) - $signed({1'b0, exp_period(3'(k))});
      if ((diff <= TOL_S) && (diff >= -TOL_S)) code = 3'(k);
    end
  end

  always_comb begin
    note_nxt   = note_out;
    valid_nxt  = note_valid;
    streak_inc = SW'(1);
    if (code == last_code)
      streak_inc = (streak == SW'(STABLE)) ? streak : streak + SW'(1);
    if (go_silent) begin
      note_nxt  = 3'd0;
      valid_nxt = 1'b0;
    end else if (meas_strobe && (streak_inc == SW'(STABLE))) begin
      note_nxt  = code;
      valid_nxt = (code != 3'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_code  <= 3'd0;
      streak     <= '0;
      note_out   <= 3'd0;
      note_valid <= 1'b0;
    end else begin
      if (go_silent) begin
        last_code <= 3'd0;
        streak    <= '0;
      end else if (meas_strobe) begin
        last_code <= code;
        streak    <= streak_inc;
      end
      note_out   <= note_nxt;
      note_valid <= valid_nxt;
    end
  end

`ifdef PIEZO_DEC_HIST_EN
  logic       note_change;
  logic [7:0] change_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_change <= 1'b0;
      change_cnt  <= 8'd0;
    end else begin
      note_change <= (note_nxt != note_out);
      if (note_nxt != note_out) change_cnt <= change_cnt + 8'd1;
    end
  end

  assign dec.note_change = note_change;
  assign dec.change_cnt  = change_cnt;
`else
  assign dec.note_change = 1'b0;
  assign dec.change_cnt  = 8'd0;
`endif

  assign dec.note_out    = note_out;
  assign dec.note_valid  = note_valid;
  assign dec.period_out  = period_out;
  assign dec.meas_strobe = meas_strobe;
endmodule

// File: tb/tb_piezo_tone_decoder.sv
// tb/tb_piezo_tone_decoder.sv - directed self-checking bench for piezo_tone_decoder
// Tone edges are placed on known prescaler phases so measured periods are exact.
module tb_piezo_tone_decoder;
  localparam int D   = 2;
  localparam int PW  = 12;
`ifdef PIEZO_DEC_HIST_EN
  localparam int HIST = 1;
`else
  localparam int HIST = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  piezo_tone_decoder_if #(.PW(PW)) bus ();

  piezo_tone_decoder #(
    .CLK_DIV(D), .PW(PW), .TOL(16), .TIMEOUT(4095), .STABLE(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .dec(bus)
  );

  int tests = 0;
  int fails = 0;
  int meas_cnt = 0;
  int chg_cnt = 0;
  int ecount = 0;
  int gap = 0;
  int cnt_before;
  bit armed = 1'b0;
  bit aligned = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] obs_q[$];

  always @(posedge clk or posedge rst) begin
    if (rst) ecount <= 0;
    else     ecount <= ecount + 1;
  end

  always @(negedge clk) begin
    if (!rst && bus.meas_strobe === 1'b1) begin
      obs_q.push_back(16'(bus.period_out));
      meas_cnt <= meas_cnt + 1;
    end
    if (!rst && bus.note_change === 1'b1) chg_cnt <= chg_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0d, required %0d", tag, obs, expv);
    end
  endtask

  task automatic drain(input string tag);
    check({tag, "_count"}, 16'(obs_q.size()), 16'(exp_q.size()));
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_period"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic wait_ticks(input int n);
    repeat (n * D) @(negedge clk);
    gap += n;
  endtask

  // Model: a tick coinciding with the rise that starts a period is not counted.
  task automatic drive_rise();
    bus.tone_in = 1'b1;
    if (armed) exp_q.push_back(16'(aligned ? gap - 1 : gap));
    armed = 1'b1;
    gap = 0;
  endtask

  task automatic tone_period(input string tag, input int h, input int l);
    drive_rise();
    wait_ticks(h);
    drain(tag);
    bus.tone_in = 1'b0;
    wait_ticks(l);
  endtask

  task automatic glitch();
    #5 drive_rise();
    @(posedge clk);
    #5 bus.tone_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    gap += 1;
  endtask

  initial begin
    bus.tone_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_note", 16'(bus.note_out), 16'd0);
    check("rst_valid", 16'(bus.note_valid), 16'd0);
    check("rst_period", 16'(bus.period_out), 16'd0);
    check("rst_strobe", 16'(bus.meas_strobe), 16'd0);
    check("rst_chg", 16'(bus.change_cnt), 16'd0);
    rst = 1'b0;

    tone_period("c1", 957, 957);
    check("arm_no_strobe", 16'(meas_cnt), 16'd0);
    tone_period("c2", 957, 957);
    check("c2_note", 16'(bus.note_out), 16'd0);
    tone_period("c3", 957, 957);
    check("c_note", 16'(bus.note_out), 16'd1);
    check("c_valid", 16'(bus.note_valid), 16'd1);

    tone_period("mix", 957, 639);
    tone_period("g1", 639, 639);
    check("mix_note", 16'(bus.note_out), 16'd1);
    tone_period("g2", 639, 639);
    check("g1_note", 16'(bus.note_out), 16'd1);
    tone_period("g3", 648, 647);
    check("g_note", 16'(bus.note_out), 16'd5);
    check("g_valid", 16'(bus.note_valid), 16'd1);
    check("cg_changes", 16'(chg_cnt), 16'(HIST * 2));
    check("cg_change_cnt", 16'(bus.change_cnt), 16'(HIST * 2));

    tone_period("t17a", 648, 647);
    check("t17a_note", 16'(bus.note_out), 16'd5);
    tone_period("t17b", 647, 647);
    check("t17_note", 16'(bus.note_out), 16'd0);
    check("t17_valid", 16'(bus.note_valid), 16'd0);
    tone_period("t16a", 647, 647);
    tone_period("t16b", 800, 800);
    check("t16_note", 16'(bus.note_out), 16'd5);
    check("t16_valid", 16'(bus.note_valid), 16'd1);
    tone_period("p1600a", 800, 800);
    tone_period("p1600b", 507, 507);
    check("p1600_note", 16'(bus.note_out), 16'd0);
    check("p1600_valid", 16'(bus.note_valid), 16'd0);
    tone_period("b1", 507, 507);

    drive_rise();
    wait_ticks(20);
    drain("b2");
    check("b_note", 16'(bus.note_out), 16'd7);
    check("b_valid", 16'(bus.note_valid), 16'd1);
    wait_ticks(487);
    bus.tone_in = 1'b0;
    wait_ticks(3583);
    check("pre_timeout_note", 16'(bus.note_out), 16'd7);
    wait_ticks(10);
    check("timeout_note", 16'(bus.note_out), 16'd0);
    check("timeout_valid", 16'(bus.note_valid), 16'd0);
    check("timeout_period", 16'(bus.period_out), 16'd0);
    check("timeout_changes", 16'(chg_cnt), 16'(HIST * 7));
    drain("timeout");
    armed = 1'b0;

    cnt_before = meas_cnt;
    tone_period("rearm", 507, 507);
    check("rearm_no_strobe", 16'(meas_cnt), 16'(cnt_before));
    tone_period("rb1", 507, 507);
    tone_period("rb2", 507, 507);
    check("rb_note", 16'(bus.note_out), 16'd7);
    check("rb_change_cnt", 16'(bus.change_cnt), 16'(HIST * 8));

    @(posedge clk);
    #5 rst = 1'b1;
    #1;
    check("arst_note", 16'(bus.note_out), 16'd0);
    check("arst_valid", 16'(bus.note_valid), 16'd0);
    check("arst_period", 16'(bus.period_out), 16'd0);
    check("arst_chg", 16'(bus.change_cnt), 16'd0);
    bus.tone_in = 1'b0;
    armed = 1'b0;
    gap = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    while (ecount % 2 == 0) @(negedge clk);
    aligned = 1'b1;

    cnt_before = meas_cnt;
    drive_rise();
    wait_ticks(10);
    bus.tone_in = 1'b0;
    wait_ticks(590);
    check("post_rst_arm_only", 16'(meas_cnt), 16'(cnt_before));
    drive_rise();
    wait_ticks(10);
    drain("coincide");
    bus.tone_in = 1'b0;
    wait_ticks(290);
    glitch();
    wait_ticks(20);
    drain("glitch");
    check("glitch_strobes", 16'(meas_cnt - cnt_before), 16'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
